// File: rtl/overlay_stream_framer.sv
// Tags an untagged pixel stream with SOF/EOL and emits AXI4-Stream video through a 2-entry skid buffer.
// Optional statistics counters are built when OVERLAY_FRAMER_STATS_EN is defined.
module overlay_stream_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_BITS   = 12
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cfg_enable,
    input  logic [DIM_BITS-1:0]   cfg_width,
    input  logic [DIM_BITS-1:0]   cfg_height,
    input  logic                  s_pix_valid,
    output logic                  s_pix_ready,
    input  logic [DATA_WIDTH-1:0] s_pix_data,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  frame_done,
    output logic                  busy
`ifdef OVERLAY_FRAMER_STATS_EN
    ,
    output logic [15:0]           stat_frames,
    output logic [15:0]           stat_stall
`endif
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  tuser;
        logic                  tlast;
    } beat_t;

    logic [0:0]          r_state;
    logic [DIM_BITS-1:0] r_wq, r_hq, r_x, r_y;
    beat_t               r_mem [2];
    logic                r_rd, r_wr;
    logic [1:0]          r_cnt;

    logic                w_cfg_ok, w_acc, w_pop, w_xlast, w_ylast;
    beat_t               w_head;

    assign w_cfg_ok = cfg_enable && (cfg_width != '0) && (cfg_height != '0);
    assign w_xlast  = (r_x == r_wq - DIM_BITS'(1));
    assign w_ylast  = (r_y == r_hq - DIM_BITS'(1));

    // Ready depends only on registered occupancy, never on downstream tready.
    assign s_pix_ready = (r_state == S_ACTIVE) && (r_cnt != 2'd2);
    assign w_acc       = s_pix_valid && s_pix_ready;
    assign frame_done  = w_acc && w_xlast && w_ylast;
    assign busy        = (r_state == S_ACTIVE);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
            r_wq    <= '0;
            r_hq    <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_ok) begin
                        r_wq    <= cfg_width;
                        r_hq    <= cfg_height;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_acc) begin
                        if (w_xlast) begin
                            r_x <= '0;
                            if (w_ylast) begin
                                r_y <= '0;
                                // Geometry is only re-sampled here, so mid-frame cfg writes wait.
                                if (w_cfg_ok) begin
                                    r_wq <= cfg_width;
                                    r_hq <= cfg_height;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_y <= r_y + DIM_BITS'(1);
                            end
                        end else begin
                            r_x <= r_x + DIM_BITS'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_head        = r_mem[r_rd];
    assign m_axis_tvalid = (r_cnt != 2'd0);
    assign m_axis_tdata  = m_axis_tvalid ? w_head.data : '0;
    assign m_axis_tuser  = m_axis_tvalid && w_head.tuser;
    assign m_axis_tlast  = m_axis_tvalid && w_head.tlast;
    assign w_pop         = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_acc) r_wr <= ~r_wr;
            if (w_pop) r_rd <= ~r_rd;
            case ({w_acc, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: the valid count gates every output.
    always_ff @(posedge ACLK) begin
        if (w_acc)
            r_mem[r_wr] <= '{data: s_pix_data, tuser: (r_x == '0) && (r_y == '0), tlast: w_xlast};
    end

`ifdef OVERLAY_FRAMER_STATS_EN
    logic [15:0] r_frames, r_stall;
    assign stat_frames = r_frames;
    assign stat_stall  = r_stall;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_frames <= '0;
            r_stall  <= '0;
        end else begin
            if (frame_done) r_frames <= r_frames + 16'd1;
            if (m_axis_tvalid && !m_axis_tready && (r_stall != 16'hFFFF))
                r_stall <= r_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_overlay_stream_framer.sv
// Directed bench for overlay_stream_framer: expected-beat table plus hand-written multi-cycle sequences.
module tb_overlay_stream_framer;

    typedef struct {
        logic [31:0] data;
        logic        tuser;
        logic        tlast;
    } vec_t;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [11:0] cfg_width = '0, cfg_height = '0;
    logic        s_pix_valid = 1'b0;
    logic        s_pix_ready;
    logic [31:0] s_pix_data = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tuser, m_axis_tlast, frame_done, busy;
`ifdef OVERLAY_FRAMER_STATS_EN
    logic [15:0] stat_frames, stat_stall;
`endif

    overlay_stream_framer #(.DATA_WIDTH(32), .DIM_BITS(12)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready), .s_pix_data(s_pix_data),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done), .busy(busy)
`ifdef OVERLAY_FRAMER_STATS_EN
        , .stat_frames(stat_frames), .stat_stall(stat_stall)
`endif
    );

    always #5 ACLK = ~ACLK;

    int   n_cmp = 0, n_fail = 0;
    vec_t tbl [20];
    vec_t got_q [$];
    int   fd_cnt = 0;
    logic [31:0] fd_data = '0;
    logic seen_full = 1'b0;
    int   tr_mode = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_v(input int i, input logic [31:0] d, input logic u, input logic l);
        tbl[i].data = d; tbl[i].tuser = u; tbl[i].tlast = l;
    endtask

    // Downstream ready pattern: 0 always ready, 1 toggling, 2 two high / three low.
    initial forever begin
        @(posedge ACLK); #1;
        cyc++;
        case (tr_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = cyc[0];
            default: m_axis_tready = ((cyc % 5) < 2);
        endcase
    end

    // Output monitor: collects beats, frame_done events, and checks AXI hold while stalled.
    logic        prev_stall = 1'b0;
    logic [33:0] prev_beat = '0;
    initial forever begin
        @(negedge ACLK);
        if (ARESETN && prev_stall)
            chk("hold_stalled", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {1'b1, prev_beat});
        prev_stall = ARESETN && m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        if (m_axis_tvalid && m_axis_tready)
            got_q.push_back('{data: m_axis_tdata, tuser: m_axis_tuser, tlast: m_axis_tlast});
        if (frame_done) begin
            fd_cnt++;
            fd_data = s_pix_data;
        end
        if (busy && !s_pix_ready) seen_full = 1'b1;
    end

    task automatic do_reset();
        tr_mode = 0;
        s_pix_valid = 1'b0;
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        @(posedge ACLK); #1;
        got_q.delete();
        fd_cnt = 0;
        seen_full = 1'b0;
    endtask

    task automatic send(input logic [31:0] d0, input int n, input int chg_after,
                        input logic [11:0] chg_w, output int cycles);
        logic acc;
        int   to;
        cycles = 0;
        for (int i = 0; i < n; i++) begin
            s_pix_valid = 1'b1;
            s_pix_data  = d0 + 32'(i);
            acc = 1'b0;
            to  = 0;
            while (!acc && to < 50) begin
                @(negedge ACLK);
                acc = s_pix_ready;
                @(posedge ACLK); #1;
                cycles++;
                to++;
            end
            if (!acc) chk("send_timeout", 64'(i), 64'(n));
            if (i == chg_after) cfg_width = chg_w;
        end
        s_pix_valid = 1'b0;
    endtask

    task automatic expect_beats(input string nm, input int base, input int n);
        int to = 0;
        while ((got_q.size() < n || m_axis_tvalid) && to < 100) begin
            @(negedge ACLK); #1;
            to++;
        end
        chk({nm, "_count"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk({nm, "_beat"}, {got_q[i].data, got_q[i].tuser, got_q[i].tlast},
                {tbl[base+i].data, tbl[base+i].tuser, tbl[base+i].tlast});
    endtask

    int c;

    initial begin
        // 4x2 frame
        set_v(0, 32'h01, 1, 0); set_v(1, 32'h02, 0, 0); set_v(2, 32'h03, 0, 0); set_v(3, 32'h04, 0, 1);
        set_v(4, 32'h05, 0, 0); set_v(5, 32'h06, 0, 0); set_v(6, 32'h07, 0, 0); set_v(7, 32'h08, 0, 1);
        // 3x1 frame then 5x1 frame
        set_v(8,  32'h21, 1, 0); set_v(9,  32'h22, 0, 0); set_v(10, 32'h23, 0, 1);
        set_v(11, 32'h24, 1, 0); set_v(12, 32'h25, 0, 0); set_v(13, 32'h26, 0, 0);
        set_v(14, 32'h27, 0, 0); set_v(15, 32'h28, 0, 1);
        // 1x1 frame, 1x3 frame
        set_v(16, 32'hAA, 1, 1);
        set_v(17, 32'h31, 1, 1); set_v(18, 32'h32, 0, 1); set_v(19, 32'h33, 0, 1);

        // Reset held with a valid config: everything stays 0
        cfg_enable = 1'b1; cfg_width = 12'd4; cfg_height = 12'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("reset_outputs", {s_pix_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, busy}, 64'd0);
        end

        // 4x2, tready=1, continuous input
        do_reset();
        send(32'h01, 8, -1, 12'd0, c);
        chk("t2_cycles", 64'(c), 64'd8);
        expect_beats("t2", 0, 8);
        chk("t2_fd_cnt", 64'(fd_cnt), 64'd1);
        chk("t2_fd_data", 64'(fd_data), 64'h08);

        // Same frame, toggling tready
        do_reset();
        tr_mode = 1;
        send(32'h01, 8, -1, 12'd0, c);
        expect_beats("t3a", 0, 8);
        chk("t3a_fd_cnt", 64'(fd_cnt), 64'd1);

        // Same frame, 3-cycle low bursts: buffer must fill and deassert ready
        do_reset();
        tr_mode = 2;
        send(32'h01, 8, -1, 12'd0, c);
        expect_beats("t3b", 0, 8);
        chk("t3b_fd_cnt", 64'(fd_cnt), 64'd1);
        chk("t3b_ready_low_full", 64'(seen_full), 64'd1);

        // 3x1 then width changed to 5 mid-frame: back-to-back, no bubble
        cfg_width = 12'd3; cfg_height = 12'd1;
        do_reset();
        send(32'h21, 8, 0, 12'd5, c);
        chk("t4_cycles", 64'(c), 64'd8);
        expect_beats("t4", 8, 8);
        chk("t4_fd_cnt", 64'(fd_cnt), 64'd2);

        // Width 0: stays idle even with input offered
        cfg_width = 12'd0; cfg_height = 12'd2;
        do_reset();
        s_pix_valid = 1'b1; s_pix_data = 32'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("t5_idle", {busy, s_pix_ready, m_axis_tvalid}, 64'd0);
        end
        s_pix_valid = 1'b0;
        chk("t5_no_beats", 64'(got_q.size()), 64'd0);

        // 1x1 frame
        cfg_width = 12'd1; cfg_height = 12'd1;
        @(posedge ACLK); #1;
        send(32'hAA, 1, -1, 12'd0, c);
        expect_beats("t5_1x1", 16, 1);
        chk("t5_fd_cnt", 64'(fd_cnt), 64'd1);
        chk("t5_fd_data", 64'(fd_data), 64'hAA);

        // 1x3: every beat is end-of-line
        cfg_width = 12'd1; cfg_height = 12'd3;
        do_reset();
        send(32'h31, 3, -1, 12'd0, c);
        expect_beats("t5_1x3", 17, 3);
        chk("t5_1x3_fd_data", 64'(fd_data), 64'h33);

        // Reset pulse after 5 of 8 beats
        cfg_width = 12'd4; cfg_height = 12'd2;
        do_reset();
        send(32'h01, 5, -1, 12'd0, c);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("t6_cleared", {s_pix_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, busy}, 64'd0);
`ifdef OVERLAY_FRAMER_STATS_EN
        chk("t6_stat_frames_rst", 64'(stat_frames), 64'd0);
`endif
        @(posedge ACLK); #1;
        got_q.delete();
        fd_cnt = 0;
        send(32'h01, 8, -1, 12'd0, c);
        expect_beats("t6", 0, 8);
        chk("t6_fd_cnt", 64'(fd_cnt), 64'd1);
        send(32'h01, 16, -1, 12'd0, c);
        repeat (4) @(posedge ACLK);
        #1;
        chk("t6_fd_cnt3", 64'(fd_cnt), 64'd3);
`ifdef OVERLAY_FRAMER_STATS_EN
        chk("t6_stat_frames", 64'(stat_frames), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
